table_deal_arbiter: RTL and testbench

TABLE_DEAL_ARBITER -- requirements
Module: table_deal_arbiter

---
 rtl/poker_pkg.sv | 28 ++
 rtl/table_deal_arbiter_if.sv | 38 +++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/table_deal_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_table_deal_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/poker_pkg.sv
// poker_pkg
// Shared types for the card-table arbiter: the player command set, the
// 6-bit card encoding, the arbiter FSM states and the fixed index width
// used for player numbers (up to eight players need three bits).
package poker_pkg;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_DEAL  = 3'd1,
        CMD_CHECK = 3'd2,
        CMD_CALL  = 3'd3,
        CMD_RAISE = 3'd4,
        CMD_FOLD  = 3'd5
    } cmd_e;

    typedef logic [5:0] card_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    localparam int MAX_PLAYERS = 8;
    localparam int IDX_W       = 3;

endpackage

// File: rtl/table_deal_arbiter_if.sv
// table_deal_arbiter_if
// Bundles the host table controls, the per-player request/ack bus and the
// dealer request/done bus.
//   slave  : the arbiter side (takes host/player/dealer inputs, drives
//            tbl_game_start, cr_ack/cr_err/cr_card and dl_req/dl_cmd/dl_player)
//   master : the environment side (players, host and dealer)
interface table_deal_arbiter_if #(
    parameter int NUM_PLAYERS = 4
);
    import poker_pkg::*;

    logic                        tbl_start;
    logic                        tbl_end;
    logic                        tbl_game_start;

    logic [NUM_PLAYERS-1:0]      cr_cmdvld;
    logic [NUM_PLAYERS-1:0][2:0] cr_cmd;
    logic [NUM_PLAYERS-1:0]      cr_ack;
    logic                        cr_err;
    card_t                       cr_card;

    logic                        dl_req;
    logic [2:0]                  dl_cmd;
    logic [2:0]                  dl_player;
    logic                        dl_done;
    card_t                       dl_card;

    modport slave (
        input  tbl_start, tbl_end, cr_cmdvld, cr_cmd, dl_done, dl_card,
        output tbl_game_start, cr_ack, cr_err, cr_card, dl_req, dl_cmd, dl_player
    );

    modport master (
        output tbl_start, tbl_end, cr_cmdvld, cr_cmd, dl_done, dl_card,
        input  tbl_game_start, cr_ack, cr_err, cr_card, dl_req, dl_cmd, dl_player
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker: selects the lowest requesting index at
// or after i_ptr, wrapping from NUM_PLAYERS-1 back to 0.
//   i_req   : request vector, one bit per player
//   i_ptr   : round-robin start index (expected < NUM_PLAYERS)
//   o_grant : one-hot grant (all zero when nobody requests)
//   o_idx   : index of the granted player
//   o_valid : at least one request is present
module rr_arbiter
    import poker_pkg::*;
#(
    parameter int NUM_PLAYERS = 4
) (
    input  logic [NUM_PLAYERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [NUM_PLAYERS-1:0] o_grant,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_valid
);

    logic [MAX_PLAYERS-1:0] w_reqExt;
    logic [MAX_PLAYERS-1:0] w_grantExt;
    logic [IDX_W-1:0]       w_cand;
    int                     w_sum;

    // The scan runs from the farthest candidate back to the pointer, so the
    // last hit is the closest one to the pointer and no "found" flag is
    // needed. Vectors are widened to eight entries so a 3-bit index is
    // always in range.
    always_comb begin
        w_reqExt                  = '0;
        w_reqExt[NUM_PLAYERS-1:0] = i_req;
        w_grantExt                = '0;
        w_cand                    = '0;
        w_sum                     = 0;
        o_idx                     = '0;
        o_valid                   = 1'b0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            w_sum = int'(i_ptr) + i;
            if (w_sum >= NUM_PLAYERS) begin
                w_sum = w_sum - NUM_PLAYERS;
            end
            w_cand = IDX_W'(w_sum);
            if (w_reqExt[w_cand]) begin
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
        w_grantExt[o_idx] = o_valid;
        o_grant           = w_grantExt[NUM_PLAYERS-1:0];
    end

endmodule

// File: rtl/table_deal_arbiter.sv
// table_deal_arbiter
// Arbitrates poker-player command requests onto a single dealer. A game is
// opened by tbl_start and closed by tbl_end; while open, one requester at a
// time is granted round-robin, its command is forwarded to the dealer and
// the result (card or error) is returned with a one-cycle cr_ack pulse.
// A dealer that stays silent for TIMEOUT wait cycles is abandoned with
// cr_err=1.
//   clk, rst : clock and synchronous active-high reset
//   bus      : table_deal_arbiter_if.slave (host, player and dealer buses)
module table_deal_arbiter
    import poker_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int TIMEOUT     = 15
) (
    input logic                 clk,
    input logic                 rst,
    table_deal_arbiter_if.slave bus
);

    localparam logic [7:0]       LAST_WAIT = 8'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PLAYERS - 1);

    arb_state_e             r_state;
    arb_state_e             w_nextState;
    logic                   r_gameActive;
    logic [IDX_W-1:0]       r_rrPtr;
    logic [IDX_W-1:0]       r_grantIdx;
    logic [2:0]             r_cmd;
    logic [7:0]             r_waitCnt;
    card_t                  r_card;
    logic                   r_err;

    logic [NUM_PLAYERS-1:0] w_winOneHot;
    logic [IDX_W-1:0]       w_winIdx;
    logic                   w_anyReq;
    logic                   w_grantNow;
    logic                   w_isNop;
    logic                   w_waitExit;
    logic                   w_dlReq;
    logic [2:0]             w_winCmd;
    logic [MAX_PLAYERS-1:0] w_ackExt;

    rr_arbiter #(
        .NUM_PLAYERS(NUM_PLAYERS)
    ) u_rrArbiter (
        .i_req  (bus.cr_cmdvld),
        .i_ptr  (r_rrPtr),
        .o_grant(w_winOneHot),
        .o_idx  (w_winIdx),
        .o_valid(w_anyReq)
    );

    // Command of the winning player, selected with the one-hot grant.
    always_comb begin
        w_winCmd = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (w_winOneHot[i]) begin
                w_winCmd = w_winCmd | bus.cr_cmd[i];
            end
        end
    end

    assign w_grantNow = r_gameActive && w_anyReq;
    assign w_isNop    = (r_cmd == CMD_NOP);
    // dl_done takes priority over the timeout because both lead to ACK and
    // the datapath checks dl_done first.
    assign w_waitExit = bus.dl_done || (r_waitCnt == LAST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and outputs. Outputs are forced low whenever rst is high so
    // a reset arriving mid-transaction silences the dealer and players at
    // once.
    always_comb begin
        w_nextState        = r_state;
        w_dlReq            = 1'b0;
        w_ackExt           = '0;
        bus.dl_cmd         = '0;
        bus.dl_player      = '0;
        bus.cr_err         = 1'b0;
        bus.cr_card        = '0;
        case (r_state)
            IDLE: begin
                if (w_grantNow) begin
                    w_nextState = GRANT;
                end
            end
            GRANT: begin
                if (w_isNop) begin
                    w_nextState = ACK;
                end else begin
                    w_dlReq     = 1'b1;
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                w_dlReq = 1'b1;
                if (w_waitExit) begin
                    w_nextState = ACK;
                end
            end
            ACK: begin
                w_ackExt[r_grantIdx] = 1'b1;
                bus.cr_err           = r_err;
                bus.cr_card          = r_card;
                w_nextState          = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (w_dlReq) begin
            bus.dl_cmd    = r_cmd;
            bus.dl_player = r_grantIdx;
        end
        bus.dl_req         = w_dlReq;
        bus.cr_ack         = w_ackExt[NUM_PLAYERS-1:0];
        bus.tbl_game_start = r_gameActive;
        if (rst) begin
            bus.dl_req         = 1'b0;
            bus.dl_cmd         = '0;
            bus.dl_player      = '0;
            bus.cr_ack         = '0;
            bus.cr_err         = 1'b0;
            bus.cr_card        = '0;
            bus.tbl_game_start = 1'b0;
        end
    end

    // Game flag, latched request, wait counter, result and pointer.
    // The card is cleared in GRANT so that a timeout leaves it at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gameActive <= 1'b0;
            r_rrPtr      <= '0;
            r_grantIdx   <= '0;
            r_cmd        <= '0;
            r_waitCnt    <= '0;
            r_card       <= '0;
            r_err        <= 1'b0;
        end else begin
            if (bus.tbl_end) begin
                r_gameActive <= 1'b0;
            end else if (bus.tbl_start) begin
                r_gameActive <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_grantNow) begin
                        r_grantIdx <= w_winIdx;
                        r_cmd      <= w_winCmd;
                    end
                end
                GRANT: begin
                    r_waitCnt <= '0;
                    r_card    <= '0;
                    r_err     <= w_isNop;
                end
                WAIT: begin
                    r_waitCnt <= r_waitCnt + 8'd1;
                    if (bus.dl_done) begin
                        r_card <= bus.dl_card;
                        r_err  <= 1'b0;
                    end else if (w_waitExit) begin
                        r_err  <= 1'b1;
                    end
                end
                ACK: begin
                    r_rrPtr <= (r_grantIdx == LAST_IDX) ? '0 : r_grantIdx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_table_deal_arbiter.sv
// tb_table_deal_arbiter
// Drives host, player and dealer sides of table_deal_arbiter and predicts
// every grant, dealer forward and acknowledgement from a transaction-level
// model: the winner is the first requester found walking forward from the
// model pointer, and ack timing/result follow from the dealer delay.
module tb_table_deal_arbiter;
    import poker_pkg::*;

    localparam int NP = 4;
    localparam int TO = 15;
    localparam int CW = 3 * NP;

    logic clk = 1'b0;
    logic rst;
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   modelPtr    = 0;
    int   winner;

    always #5 clk = ~clk;

    table_deal_arbiter_if #(.NUM_PLAYERS(NP)) bus();

    table_deal_arbiter #(
        .NUM_PLAYERS(NP),
        .TIMEOUT    (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, 32'({bus.tbl_game_start, bus.cr_ack, bus.cr_err, bus.cr_card,
                              bus.dl_req, bus.dl_cmd, bus.dl_player}), 32'd0);
    endtask

    function automatic int modelPick(input logic [NP-1:0] mask, input int ptr);
        int cand;
        for (int k = 0; k < NP; k++) begin
            cand = (ptr + k) % NP;
            if (((mask >> cand) & 1) != 0) return cand;
        end
        return -1;
    endfunction

    function automatic logic [CW-1:0] oneCmd(input int who, input logic [2:0] c);
        logic [CW-1:0] v;
        v = '0;
        v[3*who +: 3] = c;
        return v;
    endfunction

    // One full transaction started from IDLE with the game open.
    // delay: dl_done arrives this many cycles after dl_req rises (1..TO);
    // any other value means the dealer never answers. endAt: cycle (counted
    // from the request cycle) in which tbl_end is pulsed, -1 for none.
    task automatic applyStimulus(input logic [NP-1:0] mask, input logic [CW-1:0] cmds,
                                 input int delay, input card_t card, input int endAt,
                                 output int win);
        logic [2:0]    expCmd;
        logic          expNop;
        logic          isDone;
        int            ackP;
        logic          expErr;
        card_t         expCard;
        logic [NP-1:0] expAck;

        win     = modelPick(mask, modelPtr);
        expCmd  = cmds[3*win +: 3];
        expNop  = (expCmd == CMD_NOP);
        isDone  = !expNop && (delay >= 1) && (delay <= TO);
        ackP    = expNop ? 2 : (isDone ? delay + 2 : TO + 2);
        expErr  = !isDone;
        expCard = isDone ? card : 6'd0;
        expAck  = '0;
        expAck[win] = 1'b1;

        bus.cr_cmdvld = mask;
        bus.cr_cmd    = cmds;
        checkOutput("idleDlReq", 32'(bus.dl_req), 32'd0);
        tick();

        checkOutput("grantDlReq", 32'(bus.dl_req), 32'(!expNop));
        if (!expNop) begin
            checkOutput("grantPlayer", 32'(bus.dl_player), 32'(win));
            checkOutput("grantCmd", 32'(bus.dl_cmd), 32'(expCmd));
        end
        bus.cr_cmd = CW'($urandom);

        for (int p = 2; p < ackP; p++) begin
            tick();
            bus.tbl_end = (p == endAt);
            if (isDone && p == delay + 1) begin
                bus.dl_done = 1'b1;
                bus.dl_card = card;
            end else begin
                bus.dl_done = 1'b0;
                bus.dl_card = card_t'($urandom);
            end
            checkOutput("waitDlReq", 32'(bus.dl_req), 32'd1);
            checkOutput("waitPlayer", 32'(bus.dl_player), 32'(win));
            checkOutput("waitCmd", 32'(bus.dl_cmd), 32'(expCmd));
            checkOutput("waitNoAck", 32'(bus.cr_ack), 32'd0);
        end
        tick();
        bus.dl_done = 1'b0;
        bus.tbl_end = 1'b0;

        checkOutput("ackVec", 32'(bus.cr_ack), 32'(expAck));
        checkOutput("ackErr", 32'(bus.cr_err), 32'(expErr));
        checkOutput("ackCard", 32'(bus.cr_card), 32'(expCard));
        checkOutput("ackDlReq", 32'(bus.dl_req), 32'd0);
        modelPtr      = (win + 1) % NP;
        bus.cr_cmdvld = mask & ~expAck;
        tick();

        checkOutput("postAck", 32'({bus.cr_ack, bus.cr_err, bus.cr_card}), 32'd0);
    endtask

    // cr_ack must never be multi-hot, and err/card must be quiet without an ack.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checkOutput("ackOneHot", 32'($onehot0(bus.cr_ack)), 32'd1);
            if (bus.cr_ack == '0) begin
                checkOutput("quietErrCard", 32'({bus.cr_err, bus.cr_card}), 32'd0);
            end
        end
    end

    task automatic pulseStart();
        bus.tbl_start = 1'b1;
        tick();
        bus.tbl_start = 1'b0;
    endtask

    initial begin
        logic [NP-1:0] rmask;
        logic [CW-1:0] rcmds;
        int            rdelay;
        int            sel;

        rst           = 1'b1;
        bus.tbl_start = 1'b0;
        bus.tbl_end   = 1'b0;
        bus.cr_cmdvld = '0;
        bus.cr_cmd    = '0;
        bus.dl_done   = 1'b0;
        bus.dl_card   = '0;
        tick();
        tick();
        checkAllZero("resetState");
        rst = 1'b0;

        // No grant while the game is closed.
        bus.cr_cmdvld = '1;
        bus.cr_cmd    = {NP{3'(CMD_DEAL)}};
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("closedNoGrant", 32'(bus.dl_req), 32'd0);
        end
        bus.cr_cmdvld = '0;

        pulseStart();
        checkOutput("gameOpen", 32'(bus.tbl_game_start), 32'd1);

        // Player 2 deal, dealer answers 3 cycles after dl_req.
        applyStimulus(4'b0100, oneCmd(2, CMD_DEAL), 3, 6'h2C, -1, winner);
        checkOutput("dealWinner", 32'(winner), 32'd2);

        // Player 1 NOP is rejected without touching the dealer.
        applyStimulus(4'b0010, oneCmd(1, CMD_NOP), 3, 6'h01, -1, winner);
        checkOutput("nopWinner", 32'(winner), 32'd1);

        // Dealer never answers: timeout.
        applyStimulus(4'b1000, oneCmd(3, CMD_RAISE), 0, 6'h3F, -1, winner);
        checkOutput("timeoutWinner", 32'(winner), 32'd3);

        // Players 0, 1, 3 hold requests: 0, 1, 3, then 0 again.
        applyStimulus(4'b1011, oneCmd(0, CMD_CALL) | oneCmd(1, CMD_FOLD) | oneCmd(3, CMD_CHECK),
                      1, 6'h05, -1, winner);
        checkOutput("rrFirst", 32'(winner), 32'd0);
        applyStimulus(4'b1011, oneCmd(0, CMD_CALL) | oneCmd(1, CMD_FOLD) | oneCmd(3, CMD_CHECK),
                      2, 6'h06, -1, winner);
        checkOutput("rrSecond", 32'(winner), 32'd1);
        applyStimulus(4'b1011, oneCmd(0, CMD_CALL) | oneCmd(1, CMD_FOLD) | oneCmd(3, CMD_CHECK),
                      1, 6'h07, -1, winner);
        checkOutput("rrThird", 32'(winner), 32'd3);
        applyStimulus(4'b1011, oneCmd(0, CMD_CALL) | oneCmd(1, CMD_FOLD) | oneCmd(3, CMD_CHECK),
                      2, 6'h08, -1, winner);
        checkOutput("rrWrap", 32'(winner), 32'd0);

        // dl_done in the very cycle the timeout would fire wins.
        applyStimulus(4'b0001, oneCmd(0, CMD_CALL), TO, 6'h15, -1, winner);
        checkOutput("lastCycleWinner", 32'(winner), 32'd0);

        // tbl_end during WAIT: command completes, pending player 0 is starved.
        applyStimulus(4'b0101, oneCmd(2, CMD_CHECK) | oneCmd(0, CMD_DEAL), 4, 6'h11, 3, winner);
        checkOutput("endWinner", 32'(winner), 32'd2);
        checkOutput("endGameDrop", 32'(bus.tbl_game_start), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("endNoGrant", 32'(bus.dl_req), 32'd0);
            checkOutput("endNoAck", 32'(bus.cr_ack), 32'd0);
        end
        bus.cr_cmdvld = '0;

        // Start and end together: end wins.
        bus.tbl_end = 1'b1;
        pulseStart();
        bus.tbl_end = 1'b0;
        checkOutput("startEndTogether", 32'(bus.tbl_game_start), 32'd0);
        pulseStart();
        checkOutput("gameReopen", 32'(bus.tbl_game_start), 32'd1);

        // Reset in the middle of WAIT.
        bus.cr_cmdvld = 4'b0100;
        bus.cr_cmd    = oneCmd(2, CMD_DEAL);
        tick();
        checkOutput("preRstPlayer", 32'(bus.dl_player), 32'(modelPick(4'b0100, modelPtr)));
        tick();
        tick();
        checkOutput("preRstWait", 32'(bus.dl_req), 32'd1);
        rst = 1'b1;
        tick();
        checkAllZero("rstMidWait");
        rst      = 1'b0;
        modelPtr = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rstNoAck", 32'(bus.cr_ack), 32'd0);
            checkOutput("rstNoReq", 32'(bus.dl_req), 32'd0);
        end
        bus.cr_cmdvld = '0;
        pulseStart();
        applyStimulus(4'b1011, {NP{3'(CMD_DEAL)}}, 2, 6'h2A, -1, winner);
        checkOutput("firstAfterRst", 32'(winner), 32'd0);

        // Randomized rounds against the transaction model.
        for (int r = 0; r < 40; r++) begin
            rmask = NP'($urandom_range(1, (1 << NP) - 1));
            for (int i = 0; i < NP; i++) begin
                rcmds[3*i +: 3] = 3'($urandom_range(0, 5));
            end
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                rdelay = 0;
            end else if (sel == 1) begin
                rdelay = TO;
            end else begin
                rdelay = int'($urandom_range(1, 6));
            end
            applyStimulus(rmask, rcmds, rdelay, card_t'($urandom), -1, winner);
        end
        bus.cr_cmdvld = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
